// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   state_t     : arbiter FSM encoding (3 bits)
//   UART_DATA_W : width of one transmitted byte
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_DONE      = 3'd3,
    ST_ABORT     = 3'd4
  } state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the byte sources, the arbiter and the UART transmitter.
//   req/req_data : level requests and per-requester bytes (byte i at [8i+7:8i])
//   ack/err      : one-cycle completion / abort pulses back to requesters
//   tx_start/tx_data/tx_busy : transmitter handshake
//   active       : arbiter not idle
// master = arbiter side, slave = requesters + transmitter side.
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ*UART_DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]             ack;
  logic [NUM_REQ-1:0]             err;
  logic                           tx_start;
  logic [UART_DATA_W-1:0]         tx_data;
  logic                           tx_busy;
  logic                           active;

  modport master (
    input  req, req_data, tx_busy,
    output ack, err, tx_start, tx_data, active
  );

  modport slave (
    output req, req_data, tx_busy,
    input  ack, err, tx_start, tx_data, active
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority encoder.
//   req   : request vector
//   ptr   : highest-priority index this round
//   valid : some request is set
//   index : first set request at or after ptr, wrapping around
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          valid,
  output logic [PW-1:0] index
);
  int j;

  // Walk offsets from farthest to nearest so the nearest hit to ptr wins.
  always_comb begin
    valid = 1'b0;
    index = '0;
    j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[j[PW-1:0]]) begin
        valid = 1'b1;
        index = PW'(j);
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between NUM_REQ byte sources.
// Grants round-robin, launches the byte, follows tx_busy through the frame
// and pulses ack (frame done) or err (start/frame timeout) to the winner.
//   clk, rst : clock, synchronous active-high reset
//   bus      : uart_tx_arbiter_if master modport (requesters + transmitter)
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 4096,
  parameter int FRAME_TIMEOUT = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_tx_arbiter_if.master     bus
);
  localparam int PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMAX = (START_TIMEOUT > FRAME_TIMEOUT) ? START_TIMEOUT : FRAME_TIMEOUT;
  localparam int CW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [CW-1:0] START_LAST = CW'(START_TIMEOUT - 1);
  localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_TIMEOUT - 1);
  localparam logic [PW-1:0] LAST_IDX   = PW'(NUM_REQ - 1);

  state_t                 state, state_nx;
  logic [PW-1:0]          ptr, ptr_nx;
  logic [PW-1:0]          sel, sel_nx;
  logic [CW-1:0]          cnt, cnt_nx, cnt_inc;
  logic                   tx_start_q, tx_start_nx;
  logic [UART_DATA_W-1:0] tx_data_q, tx_data_nx;
  logic                   pick_vld;
  logic [PW-1:0]          pick_idx;
  logic [PW-1:0]          ptr_after;

  logic [NUM_REQ-1:0][UART_DATA_W-1:0] req_bytes;
  assign req_bytes = bus.req_data;

  rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
    .req   (bus.req),
    .ptr   (ptr),
    .valid (pick_vld),
    .index (pick_idx)
  );

  // Saturating so a long stall can never wrap back under the limit.
  assign cnt_inc   = (cnt == '1) ? cnt : cnt + CW'(1);
  assign ptr_after = (sel == LAST_IDX) ? '0 : sel + PW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      sel        <= '0;
      cnt        <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state      <= state_nx;
      ptr        <= ptr_nx;
      sel        <= sel_nx;
      cnt        <= cnt_nx;
      tx_start_q <= tx_start_nx;
      tx_data_q  <= tx_data_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    ptr_nx      = ptr;
    sel_nx      = sel;
    cnt_nx      = cnt;
    tx_start_nx = tx_start_q;
    tx_data_nx  = tx_data_q;
    case (state)
      ST_IDLE: begin
        // Capture the winner's byte now; its req_data is not looked at again.
        if (pick_vld) begin
          sel_nx      = pick_idx;
          tx_data_nx  = req_bytes[pick_idx];
          tx_start_nx = 1'b1;
          cnt_nx      = '0;
          state_nx    = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        if (bus.tx_busy) begin
          tx_start_nx = 1'b0;
          cnt_nx      = '0;
          state_nx    = ST_WAIT_DONE;
        end else if (cnt == START_LAST) begin
          tx_start_nx = 1'b0;
          cnt_nx      = '0;
          state_nx    = ST_ABORT;
        end else begin
          cnt_nx = cnt_inc;
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.tx_busy) begin
          cnt_nx   = '0;
          state_nx = ST_DONE;
        end else if (cnt == FRAME_LAST) begin
          cnt_nx   = '0;
          state_nx = ST_ABORT;
        end else begin
          cnt_nx = cnt_inc;
        end
      end
      ST_DONE, ST_ABORT: begin
        ptr_nx   = ptr_after;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // ack/err decode straight from the terminal states: one bit, one cycle.
  always_comb begin
    bus.ack = '0;
    bus.err = '0;
    if (state == ST_DONE)  bus.ack[sel] = 1'b1;
    if (state == ST_ABORT) bus.err[sel] = 1'b1;
  end

  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.active   = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
  localparam int NR = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NR)) bif ();

  uart_tx_arbiter #(
    .NUM_REQ(NR), .START_TIMEOUT(16), .FRAME_TIMEOUT(100)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  int tests = 0;
  int fails = 0;

  // Transmitter model: 0 = normal (busy 3 cycles after start, held len cycles),
  // 1 = never busy, 2 = busy stuck high once started.
  int mode = 0;
  int len  = 40;
  int phase = 0;
  int mc = 0;
  bit model_clr = 1'b0;

  always @(negedge clk) begin
    if (model_clr || mode == 1) begin
      bif.tx_busy = 1'b0;
      phase = 0;
    end else if (mode == 2) begin
      if (bif.tx_start) bif.tx_busy = 1'b1;
    end else begin
      case (phase)
        0: if (bif.tx_start) begin phase = 1; mc = 1; end
        1: if (mc == 3) begin bif.tx_busy = 1'b1; phase = 2; mc = 1; end else mc++;
        default: if (mc == len) begin bif.tx_busy = 1'b0; phase = 0; end else mc++;
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bif.req = '0;
    model_clr = 1'b1;
    step();
    step();
    rst = 1'b0;
    model_clr = 1'b0;
  endtask

  // One complete frame from IDLE; drops all requests the cycle after ack.
  task automatic run_frame(input string nm, input logic [3:0] r, input logic [31:0] d,
                           input logic [7:0] ed, input logic [3:0] ea, input logic [1:0] ep);
    bit seen_busy;
    bit done;
    bif.req = r;
    bif.req_data = d;
    check({nm, "_idle"}, bif.tx_start, 0);
    step();
    check({nm, "_start"}, bif.tx_start, 1);
    check({nm, "_data"}, bif.tx_data, ed);
    seen_busy = 1'b0;
    done = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      step();
      if (!seen_busy && bif.tx_busy === 1'b1) begin
        seen_busy = 1'b1;
        check({nm, "_start_drop"}, bif.tx_start, 0);
      end
      if ((bif.ack | bif.err) != 0) done = 1'b1;
    end
    check({nm, "_ack"}, bif.ack, ea);
    check({nm, "_err"}, bif.err, 0);
    bif.req = '0;
    step();
    check({nm, "_ack_once"}, bif.ack, 0);
    check({nm, "_ptr"}, dut.ptr, ep);
    check({nm, "_idle_after"}, bif.active, 0);
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [7:0]  exp_data;
    logic [3:0]  exp_ack;
    logic [1:0]  exp_ptr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int n;
    logic [7:0] rot_d[5];
    logic [3:0] rot_a[5];

    // Applied in order from reset (ptr=0); each row's expectations depend on the ptr left by the previous row.
    vecs[0] = '{4'b0100, 32'h00A50000, 8'hA5, 4'b0100, 2'd3};
    vecs[1] = '{4'b0011, 32'h13121110, 8'h10, 4'b0001, 2'd1};
    vecs[2] = '{4'b0011, 32'h13121110, 8'h11, 4'b0010, 2'd2};
    vecs[3] = '{4'b1001, 32'h13121110, 8'h13, 4'b1000, 2'd0};
    vecs[4] = '{4'b1000, 32'h13121110, 8'h13, 4'b1000, 2'd0};
    vecs[5] = '{4'b0110, 32'h13121110, 8'h11, 4'b0010, 2'd2};
    vecs[6] = '{4'b0001, 32'h13121110, 8'h10, 4'b0001, 2'd1};
    vecs[7] = '{4'b1100, 32'h13121110, 8'h12, 4'b0100, 2'd3};

    bif.req = '0;
    bif.req_data = '0;
    do_reset();
    check("rst_tx_start", bif.tx_start, 0);
    check("rst_tx_data", bif.tx_data, 0);
    check("rst_ack", bif.ack, 0);
    check("rst_err", bif.err, 0);
    check("rst_active", bif.active, 0);
    check("rst_ptr", dut.ptr, 0);
    step();
    check("idle_noreq_active", bif.active, 0);

    // Table-driven single frames
    mode = 0; len = 40;
    for (int i = 0; i < 8; i++)
      run_frame($sformatf("vec%0d", i), vecs[i].req, vecs[i].data,
                vecs[i].exp_data, vecs[i].exp_ack, vecs[i].exp_ptr);

    // Rotation with all requesters continuously high
    do_reset();
    len = 5;
    rot_d = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    rot_a = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    bif.req = 4'b1111;
    bif.req_data = 32'h13121110;
    for (int g = 0; g < 5; g++) begin
      n = 0;
      while (bif.tx_start !== 1'b1 && n < 100) begin step(); n++; end
      check($sformatf("rot%0d_data", g), bif.tx_data, rot_d[g]);
      n = 0;
      while ((bif.ack | bif.err) == 0 && n < 300) begin step(); n++; end
      check($sformatf("rot%0d_ack", g), bif.ack, rot_a[g]);
      step();
      check($sformatf("rot%0d_gap_idle", g), bif.tx_start, 0);
      step();
      check($sformatf("rot%0d_regrant", g), bif.tx_start, 1);
    end
    bif.req = '0;

    // Start timeout: transmitter never goes busy
    do_reset();
    mode = 1;
    bif.req = 4'b0011;
    bif.req_data = 32'h0000BBAA;
    step();
    n = 0;
    while (bif.tx_start === 1'b1 && n < 100) begin n++; step(); end
    check("st_to_start_cycles", n, 16);
    check("st_to_err", bif.err, 4'b0001);
    check("st_to_ack", bif.ack, 0);
    bif.req = 4'b0010;
    step();
    check("st_to_ptr", dut.ptr, 1);
    check("st_to_err_once", bif.err, 0);
    step();
    check("st_to_next_start", bif.tx_start, 1);
    check("st_to_next_data", bif.tx_data, 8'hBB);
    bif.req = '0;

    // Frame timeout: busy stuck high
    do_reset();
    mode = 2;
    bif.req = 4'b0001;
    bif.req_data = 32'h000000AA;
    step();
    n = 0;
    while (bif.tx_start === 1'b1 && n < 100) begin step(); n++; end
    n = 0;
    while (bif.err == 0 && bif.ack == 0 && n < 300) begin n++; step(); end
    check("fr_to_wait_cycles", n, 100);
    check("fr_to_err", bif.err, 4'b0001);
    check("fr_to_ack", bif.ack, 0);
    bif.req = '0;
    step();
    check("fr_to_active", bif.active, 0);
    check("fr_to_err_once", bif.err, 0);

    // Reset in the middle of WAIT_DONE
    do_reset();
    mode = 0; len = 40;
    bif.req = 4'b0100;
    bif.req_data = 32'h00A50000;
    n = 0;
    while (bif.tx_busy !== 1'b1 && n < 50) begin step(); n++; end
    repeat (5) step();
    check("mid_active_before", bif.active, 1);
    rst = 1'b1;
    bif.req = '0;
    step();
    rst = 1'b0;
    check("mid_rst_tx_start", bif.tx_start, 0);
    check("mid_rst_tx_data", bif.tx_data, 0);
    check("mid_rst_active", bif.active, 0);
    check("mid_rst_ptr", dut.ptr, 0);
    n = 0;
    for (int c = 0; c < 60; c++) begin
      if ((bif.ack | bif.err) != 0) n++;
      step();
    end
    check("mid_rst_no_pulse", n, 0);
    run_frame("post_rst", 4'b0010, 32'h0000C300, 8'hC3, 4'b0010, 2'd2);

    // req[1] drops mid-frame while req[2] rises
    bif.req = 4'b0010;
    bif.req_data = 32'h00DDCC00;
    step();
    check("swap_data1", bif.tx_data, 8'hCC);
    n = 0;
    while (bif.tx_busy !== 1'b1 && n < 50) begin step(); n++; end
    bif.req = 4'b0100;
    n = 0;
    while ((bif.ack | bif.err) == 0 && n < 300) begin step(); n++; end
    check("swap_ack1", bif.ack, 4'b0010);
    step();
    step();
    check("swap_start2", bif.tx_start, 1);
    check("swap_data2", bif.tx_data, 8'hDD);
    n = 0;
    while ((bif.ack | bif.err) == 0 && n < 300) begin step(); n++; end
    check("swap_ack2", bif.ack, 4'b0100);
    bif.req = '0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
